multicycle_ctrl: RTL and testbench

- Main sequencing FSM of the multi-cycle RV32I core.
- Drives the PC/instruction-fetch pair (pc_we, pc_sel, ir_we) and the register file, ALU-operand and data-memory strobes for each instruction.
- Walks each instruction through FETCH, DECODE, EXEC, MEM and WB, waiting on memory ready handshakes.
- Traps and halts on an illegal opcode or a memory timeout.

---
 rtl/riscv_ctrl_pkg.sv | 76 +++++++
 rtl/branch_cond.sv | 34 +++
 rtl/multicycle_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_ctrl_pkg
// Brief    : Shared encodings for the RV32I control path (states, opcodes,
//            mux select codes, instruction classes).
// Revision : 1.0
// ============================================================================
package riscv_ctrl_pkg;

  localparam logic [2:0] c_ST_FETCH  = 3'd0;
  localparam logic [2:0] c_ST_DECODE = 3'd1;
  localparam logic [2:0] c_ST_EXEC   = 3'd2;
  localparam logic [2:0] c_ST_MEM    = 3'd3;
  localparam logic [2:0] c_ST_WB     = 3'd4;
  localparam logic [2:0] c_ST_TRAP   = 3'd7;

  typedef enum logic [2:0] {
    ST_FETCH  = c_ST_FETCH,
    ST_DECODE = c_ST_DECODE,
    ST_EXEC   = c_ST_EXEC,
    ST_MEM    = c_ST_MEM,
    ST_WB     = c_ST_WB,
    ST_TRAP   = c_ST_TRAP
  } state_e;

  localparam logic [4:0] c_OPC_LOAD   = 5'b00000;
  localparam logic [4:0] c_OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] c_OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] c_OPC_STORE  = 5'b01000;
  localparam logic [4:0] c_OPC_OP     = 5'b01100;
  localparam logic [4:0] c_OPC_LUI    = 5'b01101;
  localparam logic [4:0] c_OPC_BRANCH = 5'b11000;
  localparam logic [4:0] c_OPC_JALR   = 5'b11001;
  localparam logic [4:0] c_OPC_JAL    = 5'b11011;

  localparam logic [1:0] c_PC_SEL_PLUS4 = 2'b00;
  localparam logic [1:0] c_PC_SEL_IMM   = 2'b01;
  localparam logic [1:0] c_PC_SEL_ALU   = 2'b10;

  localparam logic [1:0] c_WB_SEL_ALU = 2'b00;
  localparam logic [1:0] c_WB_SEL_MEM = 2'b01;
  localparam logic [1:0] c_WB_SEL_PC4 = 2'b10;

  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_LOAD   = 4'd1,
    CLS_OP_IMM = 4'd2,
    CLS_AUIPC  = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_OP     = 4'd5,
    CLS_LUI    = 4'd6,
    CLS_BRANCH = 4'd7,
    CLS_JALR   = 4'd8,
    CLS_JAL    = 4'd9
  } instr_class_e;

  // CLS_NONE doubles as the "illegal opcode" result.
  function automatic instr_class_e classify(input logic [4:0] opc);
    instr_class_e cls;
    case (opc)
      c_OPC_LOAD:   cls = CLS_LOAD;
      c_OPC_OP_IMM: cls = CLS_OP_IMM;
      c_OPC_AUIPC:  cls = CLS_AUIPC;
      c_OPC_STORE:  cls = CLS_STORE;
      c_OPC_OP:     cls = CLS_OP;
      c_OPC_LUI:    cls = CLS_LUI;
      c_OPC_BRANCH: cls = CLS_BRANCH;
      c_OPC_JALR:   cls = CLS_JALR;
      c_OPC_JAL:    cls = CLS_JAL;
      default:      cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cond.sv
`default_nettype none
// ============================================================================
// Module   : branch_cond
// Brief    : Combinational RV32I branch resolution from funct3 and ALU flags.
// Revision : 1.0
// ============================================================================
module branch_cond (
  input  logic [2:0] funct3,
  input  logic [1:0] flag,
  output logic       taken,
  output logic       illegal
);

  logic w_zero;
  logic w_lt;

  assign w_zero = flag[0];
  assign w_lt   = flag[1];

  // The ALU already picked signed vs unsigned compare, so BLT/BLTU share a row.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      3'b000:         taken = w_zero;
      3'b001:         taken = !w_zero;
      3'b100, 3'b110: taken = w_lt;
      3'b101, 3'b111: taken = !w_lt;
      default:        illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Main sequencing FSM of the multi-cycle RV32I core.
//            Define MULTICYCLE_CTRL_PERF_EN to add cycle/instret counters.
// Revision : 1.0
// ============================================================================
module multicycle_ctrl #(
  parameter int unsigned MAX_WAIT = 0,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [1:0]  flag,
  input  logic        if_ready,
  input  logic        mem_ready,
  output logic        if_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        mem_re,
  output logic        mem_we,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [2:0]  state
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  import riscv_ctrl_pkg::*;

  localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] C_WAIT_ONE = WAIT_W'(1);

  state_e            state_q, state_d;
  instr_class_e      class_q, class_d;
  logic [WAIT_W-1:0] wait_q,  wait_d;

  logic w_taken;
  logic w_br_illegal;
  logic w_waiting;
  logic w_timeout;

  branch_cond u_branch_cond (
    .funct3  (funct3),
    .flag    (flag),
    .taken   (w_taken),
    .illegal (w_br_illegal)
  );

  // Only the ready input belonging to the current state counts as a wait.
  always_comb begin
    w_waiting = ((state_q == ST_FETCH) && !if_ready) ||
                ((state_q == ST_MEM)   && !mem_ready);
    w_timeout = (MAX_WAIT != 0) && w_waiting && (wait_q == C_MAX_WAIT);
  end

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    if_req    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = c_PC_SEL_PLUS4;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = c_WB_SEL_ALU;
    trap      = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if_req = 1'b1;
        if (if_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (w_timeout) begin
          state_d = ST_TRAP;
        end
      end

      ST_DECODE: begin
        class_d = classify(opcode);
        state_d = (class_d == CLS_NONE) ? ST_TRAP : ST_EXEC;
      end

      ST_EXEC: begin
        alu_a_sel = (class_q == CLS_AUIPC);
        alu_b_sel = (class_q != CLS_OP) && (class_q != CLS_BRANCH);
        case (class_q)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH: begin
            if (w_br_illegal) begin
              state_d = ST_TRAP;
            end else begin
              pc_we   = 1'b1;
              pc_sel  = w_taken ? c_PC_SEL_IMM : c_PC_SEL_PLUS4;
              state_d = ST_FETCH;
            end
          end
          CLS_NONE: state_d = ST_TRAP;
          default:  state_d = ST_WB;
        endcase
      end

      ST_MEM: begin
        mem_re = (class_q == CLS_LOAD);
        mem_we = (class_q == CLS_STORE);
        if (mem_ready) begin
          if (class_q == CLS_LOAD) begin
            state_d = ST_WB;
          end else begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end
        end else if (w_timeout) begin
          state_d = ST_TRAP;
        end
      end

      ST_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = ST_FETCH;
        case (class_q)
          CLS_LOAD:          wb_sel = c_WB_SEL_MEM;
          CLS_JAL, CLS_JALR: wb_sel = c_WB_SEL_PC4;
          default:           wb_sel = c_WB_SEL_ALU;
        endcase
        case (class_q)
          CLS_JAL:  pc_sel = c_PC_SEL_IMM;
          CLS_JALR: pc_sel = c_PC_SEL_ALU;
          default:  pc_sel = c_PC_SEL_PLUS4;
        endcase
      end

      ST_TRAP: trap = 1'b1;

      default: state_d = ST_TRAP;
    endcase
  end

  // Counter restarts on any state change and sticks at all-ones.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (w_waiting && (wait_q != '1)) begin
      wait_d = wait_q + C_WAIT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      class_q <= CLS_NONE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      wait_q  <= wait_d;
    end
  end

  assign state = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q,   cycle_cnt_d;
  logic [31:0] instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q != ST_TRAP) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
    if (pc_we) begin
      instret_cnt_d = instret_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Randomized scoreboard bench for multicycle_ctrl (MAX_WAIT=4).
// Revision : 1.0
// ============================================================================
module tb_multicycle_ctrl;

  localparam int unsigned MAX_WAIT  = 4;
  localparam int unsigned WAIT_W    = 8;
  localparam int          NUM_INSTR = 300;
  localparam int          MAX_CYC   = 60000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [1:0] flag = '0;
  logic       if_ready = 1'b0;
  logic       mem_ready = 1'b0;
  logic       if_req, ir_we, pc_we, alu_a_sel, alu_b_sel;
  logic       mem_re, mem_we, reg_we, trap;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] state;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .flag(flag),
    .if_ready(if_ready), .mem_ready(mem_ready), .if_req(if_req), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we), .wb_sel(wb_sel),
    .trap(trap), .state(state)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  typedef struct {
    logic [4:0] opc;
    logic [2:0] f3;
    logic [1:0] flg;
    int         wf;      // low if_ready cycles before the ready pulse
    int         wm;      // low mem_ready cycles before the ready pulse
    bit         rst_mid; // pull reset in the third MEM cycle
  } stim_t;

  typedef struct {
    bit         trap;
    int         lat;     // cycles from first FETCH cycle to the pc_we / trap cycle
    logic [1:0] pc_sel;
    logic [2:0] st;
    int         reg_cnt;
    logic [1:0] wb_sel;
    int         ir_cnt, re_cnt, we_cnt, a_cnt, b_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic [4:0] opc, input logic [2:0] f3,
                               input logic [1:0] flg, input int wf, input int wm,
                               input bit rm);
    stim_t s;
    s.opc = opc; s.f3 = f3; s.flg = flg; s.wf = wf; s.wm = wm; s.rst_mid = rm;
    return s;
  endfunction

  function automatic string cls_name(input logic [4:0] opc);
    case (opc)
      5'b00000: return "LOAD";
      5'b00100: return "OPIMM";
      5'b00101: return "AUIPC";
      5'b01000: return "STORE";
      5'b01100: return "OP";
      5'b01101: return "LUI";
      5'b11000: return "BRANCH";
      5'b11001: return "JALR";
      5'b11011: return "JAL";
      default:  return "ILLEGAL";
    endcase
  endfunction

  // Timeline model: FETCH takes wf+1 cycles, DECODE/EXEC/WB one each, MEM wm+1.
  function automatic exp_t model(input stim_t s);
    exp_t  e;
    string c;
    int    f;
    bit    taken;
    e.trap = 1'b0; e.lat = 0; e.pc_sel = 2'b00; e.st = 3'd7; e.reg_cnt = 0;
    e.wb_sel = 2'b00; e.ir_cnt = 0; e.re_cnt = 0; e.we_cnt = 0; e.a_cnt = 0; e.b_cnt = 0;
    if (s.wf > int'(MAX_WAIT)) begin
      e.trap = 1'b1; e.lat = MAX_WAIT + 2;
      return e;
    end
    f = s.wf + 1;
    e.ir_cnt = 1;
    c = cls_name(s.opc);
    if (c == "ILLEGAL") begin
      e.trap = 1'b1; e.lat = f + 2;
    end else if (c == "BRANCH") begin
      if (s.f3 == 3'd2 || s.f3 == 3'd3) begin
        e.trap = 1'b1; e.lat = f + 3;
      end else begin
        case (s.f3)
          3'd0:    taken = s.flg[0];
          3'd1:    taken = !s.flg[0];
          3'd4:    taken = s.flg[1];
          3'd6:    taken = s.flg[1];
          default: taken = !s.flg[1];
        endcase
        e.lat = f + 2; e.st = 3'd2; e.pc_sel = taken ? 2'b01 : 2'b00;
      end
    end else if (c == "LOAD" || c == "STORE") begin
      e.b_cnt = 1;
      if (s.wm > int'(MAX_WAIT)) begin
        e.trap = 1'b1; e.lat = f + MAX_WAIT + 4;
        if (c == "LOAD") e.re_cnt = MAX_WAIT + 1; else e.we_cnt = MAX_WAIT + 1;
      end else if (c == "STORE") begin
        e.lat = f + 3 + s.wm; e.st = 3'd3; e.we_cnt = s.wm + 1;
      end else begin
        e.lat = f + 4 + s.wm; e.st = 3'd4; e.re_cnt = s.wm + 1;
        e.reg_cnt = 1; e.wb_sel = 2'b01;
      end
    end else begin
      e.lat = f + 3; e.st = 3'd4; e.reg_cnt = 1;
      e.a_cnt = (c == "AUIPC") ? 1 : 0;
      e.b_cnt = (c == "OP") ? 0 : 1;
      e.wb_sel = (c == "JAL" || c == "JALR") ? 2'b10 : 2'b00;
      e.pc_sel = (c == "JAL") ? 2'b01 : (c == "JALR") ? 2'b10 : 2'b00;
    end
    return e;
  endfunction

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(99));
    if (r < 5)  return MAX_WAIT + 1 + int'($urandom_range(3));
    if (r < 60) return 0;
    return int'($urandom_range(MAX_WAIT, 1));
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    logic [4:0] legal [9];
    legal = '{5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
              5'b01101, 5'b11000, 5'b11001, 5'b11011};
    if ($urandom_range(99) < 85) begin
      s.opc = legal[$urandom_range(8)];
    end else begin
      s.opc = 5'($urandom);
      while (cls_name(s.opc) != "ILLEGAL") s.opc = 5'($urandom);
    end
    s.f3 = 3'($urandom);
    s.flg = 2'($urandom);
    s.wf = rand_wait();
    s.wm = rand_wait();
    s.rst_mid = (s.wm >= 3) && (s.wm <= int'(MAX_WAIT)) && ($urandom_range(19) == 0);
    return s;
  endfunction

  // Stimulus and memory responders, driven 1 time unit after each rising edge.
  initial begin
    stim_t dir[$];
    stim_t cur;
    int    issued = 0;
    int    fcnt = 0;
    int    mcnt = 0;
    int    trap_cyc = 0;
    bit    prev_req = 1'b0;
    bit    just_rst = 1'b0;
    bit    done = 1'b0;

    dir.push_back(mk(5'b00100, 3'd0, 2'b00, 0, 0, 1'b0));  // OP-IMM zero wait
    dir.push_back(mk(5'b00000, 3'd2, 2'b00, 0, 2, 1'b0));  // LOAD, ready in 3rd MEM cycle
    dir.push_back(mk(5'b11000, 3'd0, 2'b01, 0, 0, 1'b0));  // BEQ taken
    dir.push_back(mk(5'b11000, 3'd0, 2'b00, 0, 0, 1'b0));  // BEQ not taken
    dir.push_back(mk(5'b11001, 3'd0, 2'b00, 0, 0, 1'b0));  // JALR
    dir.push_back(mk(5'b11011, 3'd0, 2'b00, 0, 0, 1'b0));  // JAL
    dir.push_back(mk(5'b11111, 3'd0, 2'b00, 0, 0, 1'b0));  // illegal opcode
    dir.push_back(mk(5'b01000, 3'd2, 2'b00, 0, 10, 1'b0)); // STORE timeout
    dir.push_back(mk(5'b01000, 3'd2, 2'b00, 0, 4, 1'b1));  // reset mid-MEM
    dir.push_back(mk(5'b01100, 3'd0, 2'b00, 4, 0, 1'b0));  // fetch wait at the limit
    dir.push_back(mk(5'b00000, 3'd0, 2'b00, 1, 4, 1'b0));  // mem wait at the limit
    dir.push_back(mk(5'b11000, 3'd2, 2'b00, 0, 0, 1'b0));  // branch funct3 010
    dir.push_back(mk(5'b01100, 3'd0, 2'b00, 5, 0, 1'b0));  // fetch timeout
    cur = dir[0];

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    just_rst = 1'b1;
    for (int c = 0; c < MAX_CYC && !done; c++) begin
      if (!reset) begin
        reset = 1'b1; just_rst = 1'b1; fcnt = 0; mcnt = 0; trap_cyc = 0;
      end
      if (if_req && (!prev_req || just_rst)) begin
        if (issued >= NUM_INSTR + 13) begin
          done = 1'b1;
        end else begin
          cur = (dir.size() > 0) ? dir.pop_front() : rand_stim();
          opcode = cur.opc; funct3 = cur.f3; flag = cur.flg;
          exp_q.push_back(model(cur));
          issued++;
          fcnt = 0;
        end
      end
      if (done) begin
        if_ready = 1'b0; mem_ready = 1'b0;
      end else begin
        if (if_req) begin
          if_ready = (fcnt == cur.wf);
          fcnt++;
        end else begin
          if_ready = ($urandom_range(3) == 0);
        end
        if (mem_re || mem_we) begin
          if (cur.rst_mid && mcnt == 2) begin
            reset = 1'b0; mem_ready = 1'b0;
          end else begin
            mem_ready = (mcnt == cur.wm);
          end
          mcnt++;
        end else begin
          mem_ready = ($urandom_range(3) == 0);
          mcnt = 0;
        end
        if (trap) begin
          trap_cyc++;
          if (trap_cyc == 20) reset = 1'b0;
        end
      end
      prev_req = if_req;
      just_rst = 1'b0;
      @(posedge clk);
      #1;
    end

    if (!done) check("cycle_budget_expired", 1, 0);
    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: accumulates per-instruction activity, compares on pc_we or trap.
  int   m_cyc, m_ir, m_re, m_we, m_a, m_b, m_reg;
  logic [1:0] m_wbs;
  bit   m_in = 1'b0;
  bit   m_prev_req = 1'b0;
  bit   m_saw_rst = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      exp_q.delete();
      m_in = 1'b0;
      m_saw_rst = 1'b1;
    end else begin
      if (m_saw_rst) begin
        check("rst_state", int'(state), 0);
        check("rst_if_req", int'(if_req), 1);
        check("rst_ir_we", int'(ir_we), int'(if_ready));
        check("rst_strobes", int'({pc_we, pc_sel, alu_a_sel, alu_b_sel, mem_re,
                                   mem_we, reg_we, wb_sel, trap}), 0);
      end
      if (if_req && (!m_prev_req || m_saw_rst)) begin
        m_in = 1'b1;
        m_cyc = 0; m_ir = 0; m_re = 0; m_we = 0; m_a = 0; m_b = 0; m_reg = 0;
        m_wbs = 2'b00;
      end
      if (m_in) begin
        m_cyc++;
        m_ir  += int'(ir_we);
        m_re  += int'(mem_re);
        m_we  += int'(mem_we);
        m_a   += int'(alu_a_sel);
        m_b   += int'(alu_b_sel);
        if (reg_we) begin
          m_reg++;
          m_wbs = wb_sel;
        end
        if (pc_we || trap) begin
          m_in = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_event", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("event_is_trap", int'(trap), int'(e.trap));
            check("latency", m_cyc, e.lat);
            check("state_at_event", int'(state), int'(e.st));
            check("ir_we_cycles", m_ir, e.ir_cnt);
            check("mem_re_cycles", m_re, e.re_cnt);
            check("mem_we_cycles", m_we, e.we_cnt);
            check("alu_a_sel_cycles", m_a, e.a_cnt);
            check("alu_b_sel_cycles", m_b, e.b_cnt);
            if (!e.trap) begin
              check("pc_sel", int'(pc_sel), int'(e.pc_sel));
              check("reg_we_cycles", m_reg, e.reg_cnt);
              if (e.reg_cnt != 0) check("wb_sel", int'(m_wbs), int'(e.wb_sel));
            end
          end
        end
      end
      if (trap) begin
        check("trap_state", int'(state), 7);
        check("trap_strobes", int'({if_req, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
                                    mem_re, mem_we, reg_we, wb_sel}), 0);
      end
      m_saw_rst = 1'b0;
    end
    m_prev_req = if_req;
  end

endmodule
`default_nettype wire
